// File: rtl/ospfb_power_accum.sv
// Power integrator for the OSPFB output stream: squares each sample, integrates ACC_LEN frames
// per bin into one of two ping-pong banks, and streams each finished spectrum with tlast.
module ospfb_power_accum #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 512,
  parameter int ACC_LEN = 4,
  parameter int ACC_WID = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [ACC_WID-1:0]      m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    sat_flag
);

  localparam int BIN_W  = $clog2(FFT_LEN);
  localparam int FRM_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int SQ_W   = 2 * WIDTH - 1;
  localparam int FIFO_D = 4;

  typedef enum logic { I_ACCUM, I_WAIT } in_st_t;
  typedef enum logic { O_IDLE, O_DUMP } out_st_t;

  // Product of a sample with itself is non-negative and fits in 2*WIDTH-1 bits.
  function automatic logic [SQ_W-1:0] square(input logic signed [WIDTH-1:0] x);
    return SQ_W'(x * x);
  endfunction

  // Returns {overflow, clamped sum}.
  function automatic logic [ACC_WID:0] sat_acc(input logic [ACC_WID-1:0] a,
                                               input logic [SQ_W-1:0]    b);
    logic [ACC_WID:0] s;
    s = {1'b0, a} + (ACC_WID+1)'(b);
    if (s[ACC_WID]) return {1'b1, {ACC_WID{1'b1}}};
    return {1'b0, s[ACC_WID-1:0]};
  endfunction

  logic [ACC_WID-1:0] mem [2*FFT_LEN];

  in_st_t             in_st_q, in_st_d;
  logic               wr_q, wr_d;
  logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
  logic [FRM_W-1:0]   frm_cnt_q, frm_cnt_d;
  logic [1:0]         full_q, full_d;
  logic               sat_q;

  logic               vld_p0, first_p0, bank_p0;
  logic [BIN_W-1:0]   bin_p0;
  logic [SQ_W-1:0]    sq_p0;
  logic [ACC_WID-1:0] old_p0;
  logic [ACC_WID:0]   acc_p0;
  logic [ACC_WID-1:0] wdata_p0;
  logic               ovf_p0;

  out_st_t            out_st_q, out_st_d;
  logic               iss_bank_q, iss_bank_d;
  logic [BIN_W-1:0]   iss_bin_q, iss_bin_d;
  logic               dr_bank_q;
  logic               rd_vld_p0, rd_last_p0;
  logic [ACC_WID-1:0] rd_data_p0;

  logic [ACC_WID-1:0] fifo_data [FIFO_D];
  logic               fifo_last [FIFO_D];
  logic [1:0]         wp_q, rp_q;
  logic [2:0]         cnt_q;

  logic xfer, bin_last, frm_last, complete, pop, free_ev, other_free;
  logic iss_ready, nxt_ready, issue;

  assign s_tready = !rst && (in_st_q == I_ACCUM);
  assign xfer     = s_tvalid && s_tready;
  assign bin_last = (bin_cnt_q == BIN_W'(FFT_LEN - 1));
  assign frm_last = (frm_cnt_q == FRM_W'(ACC_LEN - 1));
  assign complete = xfer && bin_last && frm_last;

  assign m_tvalid = !rst && (cnt_q != 3'd0);
  assign m_tdata  = m_tvalid ? fifo_data[rp_q] : '0;
  assign m_tlast  = m_tvalid && fifo_last[rp_q];
  assign sat_flag = sat_q;
  assign pop      = m_tvalid && m_tready;
  assign free_ev  = pop && m_tlast;

  // A freeing in this very cycle counts, so bank-free and bank-complete together never stall.
  assign other_free = !full_q[~wr_q] || (free_ev && (dr_bank_q == ~wr_q));

  // A bank may be read out only once no accumulate write to it is still in flight.
  assign iss_ready = full_q[iss_bank_q]  && !(vld_p0 && (bank_p0 == iss_bank_q));
  assign nxt_ready = full_q[~iss_bank_q] && !(vld_p0 && (bank_p0 == ~iss_bank_q));
  assign issue     = (out_st_q == O_DUMP) && ((cnt_q + 3'(rd_vld_p0)) < 3'(FIFO_D));

  always_comb begin
    in_st_d   = in_st_q;
    wr_d      = wr_q;
    bin_cnt_d = bin_cnt_q;
    frm_cnt_d = frm_cnt_q;
    full_d    = full_q;
    if (free_ev) full_d[dr_bank_q] = 1'b0;
    case (in_st_q)
      I_ACCUM: begin
        if (xfer) begin
          bin_cnt_d = bin_cnt_q + 1'b1;
          if (bin_last) frm_cnt_d = frm_last ? '0 : frm_cnt_q + 1'b1;
          if (complete) begin
            full_d[wr_q] = 1'b1;
            if (other_free) wr_d = ~wr_q;
            else            in_st_d = I_WAIT;
          end
        end
      end
      I_WAIT: begin
        if (other_free) begin
          wr_d    = ~wr_q;
          in_st_d = I_ACCUM;
        end
      end
      default: in_st_d = I_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_st_q   <= I_ACCUM;
      wr_q      <= 1'b0;
      bin_cnt_q <= '0;
      frm_cnt_q <= '0;
      full_q    <= 2'b00;
    end else begin
      in_st_q   <= in_st_d;
      wr_q      <= wr_d;
      bin_cnt_q <= bin_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      full_q    <= full_d;
    end
  end

  // Stage p0: capture square and previous bin value
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= xfer;
  end

  always_ff @(posedge clk) begin
    first_p0 <= (frm_cnt_q == '0);
    bank_p0  <= wr_q;
    bin_p0   <= bin_cnt_q;
    sq_p0    <= square(s_tdata);
    old_p0   <= mem[{wr_q, bin_cnt_q}];
  end

  // Stage p1: saturating add and bank write-back
  always_comb begin
    acc_p0   = sat_acc(old_p0, sq_p0);
    ovf_p0   = !first_p0 && acc_p0[ACC_WID];
    wdata_p0 = first_p0 ? ACC_WID'(sq_p0) : acc_p0[ACC_WID-1:0];
  end

  always_ff @(posedge clk) begin
    if (vld_p0) mem[{bank_p0, bin_p0}] <= wdata_p0;
  end

  always_ff @(posedge clk) begin
    if (rst)                  sat_q <= 1'b0;
    else if (vld_p0 && ovf_p0) sat_q <= 1'b1;
  end

  // Issue side runs ahead of the consumer; it hops straight onto the next full bank.
  always_comb begin
    out_st_d   = out_st_q;
    iss_bank_d = iss_bank_q;
    iss_bin_d  = iss_bin_q;
    case (out_st_q)
      O_IDLE: begin
        if (iss_ready) begin
          out_st_d  = O_DUMP;
          iss_bin_d = '0;
        end
      end
      O_DUMP: begin
        if (issue) begin
          iss_bin_d = iss_bin_q + 1'b1;
          if (iss_bin_q == BIN_W'(FFT_LEN - 1)) begin
            iss_bank_d = ~iss_bank_q;
            if (!nxt_ready) out_st_d = O_IDLE;
          end
        end
      end
      default: out_st_d = O_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_st_q   <= O_IDLE;
      iss_bank_q <= 1'b0;
      iss_bin_q  <= '0;
      dr_bank_q  <= 1'b0;
      rd_vld_p0  <= 1'b0;
    end else begin
      out_st_q   <= out_st_d;
      iss_bank_q <= iss_bank_d;
      iss_bin_q  <= iss_bin_d;
      rd_vld_p0  <= issue;
      if (free_ev) dr_bank_q <= ~dr_bank_q;
    end
  end

  // Stage p0 (read side): registered bank read feeding the skid FIFO
  always_ff @(posedge clk) begin
    rd_data_p0 <= mem[{iss_bank_q, iss_bin_q}];
    rd_last_p0 <= (iss_bin_q == BIN_W'(FFT_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p0) begin
      fifo_data[wp_q] <= rd_data_p0;
      fifo_last[wp_q] <= rd_last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + 2'(rd_vld_p0);
      rp_q  <= rp_q + 2'(pop);
      cnt_q <= cnt_q + 3'(rd_vld_p0) - 3'(pop);
    end
  end

endmodule

// File: tb/tb_ospfb_power_accum.sv
// Scoreboard bench for ospfb_power_accum: a per-integration power model feeds an expected queue,
// and a free-running monitor compares every output beat and the stall-hold behaviour.
module tb_ospfb_power_accum;

  localparam int WIDTH   = 16;
  localparam int FFT_LEN = 8;
  localparam int ACC_LEN = 2;
  localparam int ACC_WID = 31;
  localparam longint MAXV = (longint'(1) << ACC_WID) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [WIDTH-1:0] s_tdata = '0;
  logic                    s_tvalid = 1'b0;
  logic                    s_tready;
  logic [ACC_WID-1:0]      m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic                    sat_flag;

  always #5 clk = ~clk;

  ospfb_power_accum #(.WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .ACC_LEN(ACC_LEN), .ACC_WID(ACC_WID)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .sat_flag(sat_flag)
  );

  typedef struct { longint data; bit last; } exp_t;
  exp_t   exp_q[$];
  longint tot [FFT_LEN];
  int     n_acc = 0;
  bit     exp_sat = 0;

  int checks = 0, passes = 0;
  int out_cnt = 0, tlast_cnt = 0, vec_idx = 0;
  int rdy_mode = 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic abort(input string name);
    checks++;
    $display("FAIL %s: wait bound expired", name);
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1);
  endtask

  // Integrated power of a bin is the sum of its squares over the integration, clamped to MAXV.
  task automatic model_accept(input logic signed [WIDTH-1:0] v);
    int bin, frm;
    longint sq;
    exp_t e;
    bin = n_acc % FFT_LEN;
    frm = (n_acc / FFT_LEN) % ACC_LEN;
    sq  = longint'(v) * longint'(v);
    if (frm == 0) tot[bin] = sq;
    else          tot[bin] += sq;
    if ((n_acc % (FFT_LEN * ACC_LEN)) == FFT_LEN * ACC_LEN - 1) begin
      for (int b = 0; b < FFT_LEN; b++) begin
        e.data = (tot[b] > MAXV) ? MAXV : tot[b];
        e.last = (b == FFT_LEN - 1);
        if (tot[b] > MAXV) exp_sat = 1;
        exp_q.push_back(e);
      end
    end
    n_acc++;
  endtask

  task automatic send(input logic signed [WIDTH-1:0] v, input int gap_pct);
    int g;
    while ($urandom_range(99) < gap_pct) begin
      s_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_tdata = v;
    s_tvalid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!s_tready) begin
      if (g == 5000) abort("send_timeout");
      g++;
      @(negedge clk);
    end
    model_accept(v);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_tvalid) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = ($urandom_range(99) < 60);
      endcase
    end
  end

  bit                 mon_stall = 0;
  logic [ACC_WID-1:0] mon_pd;
  logic               mon_pl;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_stall = 0;
    end else begin
      if (mon_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, mon_pd);
        check("hold_last", m_tlast, mon_pl);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got data %0d, expected no output", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("data[%0d]", out_cnt), m_tdata, e.data);
          check($sformatf("last[%0d]", out_cnt), m_tlast, e.last);
        end
        out_cnt++;
        if (m_tlast) begin tlast_cnt++; vec_idx = 0; end
        else vec_idx++;
      end
      mon_stall = m_tvalid && !m_tready;
      mon_pd    = m_tdata;
      mon_pl    = m_tlast;
    end
  end

  initial begin
    #3_000_000;
    abort("global_timeout");
  end

  initial begin
    logic signed [WIDTH-1:0] v;
    int lat, g;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_s_tready", s_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("s_tready_after_rst", s_tready, 1);
    cycles(2);

    // Constant +3, latency of first output
    for (int i = 0; i < FFT_LEN * ACC_LEN; i++) send(16'sd3, 0);
    lat = 0;
    while (!m_tvalid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("first_valid_within_6", (lat >= 1 && lat <= 6), 1);
    wait_drain("const3");

    // Ramp k-4 per bin
    for (int f = 0; f < ACC_LEN; f++)
      for (int k = 0; k < FFT_LEN; k++) send(WIDTH'(k - 4), 0);
    wait_drain("ramp");
    check("sat_clear_before_sat", sat_flag, exp_sat);

    // Saturation with most-negative input
    for (int i = 0; i < FFT_LEN * ACC_LEN; i++) send(-16'sd32768, 0);
    wait_drain("sat");
    check("sat_flag_set", sat_flag, exp_sat);

    // Full backpressure: two integrations accepted, then input stalls
    rdy_mode = 0;
    cycles(3);
    for (int i = 0; i < 2 * FFT_LEN * ACC_LEN; i++) send(WIDTH'($urandom), 0);
    v = WIDTH'($urandom);
    s_tdata = v;
    s_tvalid = 1'b1;
    cycles(20);
    check("bp_s_tready_low", s_tready, 0);
    check("bp_m_tvalid_high", m_tvalid, 1);
    check("bp_nothing_consumed", exp_q.size(), 2 * FFT_LEN);
    rdy_mode = 1;
    send(v, 0);
    for (int i = 1; i < FFT_LEN * ACC_LEN; i++) send(WIDTH'($urandom), 0);
    wait_drain("backpressure");

    // Random valid/ready, 20 integrations
    tlast_cnt = 0;
    rdy_mode = 2;
    for (int i = 0; i < 20 * FFT_LEN * ACC_LEN; i++) send(WIDTH'($urandom), 30);
    rdy_mode = 1;
    wait_drain("random");
    check("random_tlast_count", tlast_cnt, 20);
    check("sat_flag_sticky", sat_flag, exp_sat);

    // Reset at output bin 3 of a dump
    for (int i = 0; i < FFT_LEN * ACC_LEN; i++) send(16'sd2, 0);
    g = 0;
    while (!(m_tvalid && vec_idx == 3) && g < 100) begin @(posedge clk); #1; g++; end
    check("reached_bin3", vec_idx, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_sat_flag", sat_flag, 0);
    check("mid_rst_s_tready", s_tready, 1);
    exp_q.delete();
    n_acc = 0;
    exp_sat = 0;
    out_cnt = 0;
    vec_idx = 0;
    cycles(20);
    check("no_stale_output", out_cnt, 0);
    for (int i = 0; i < FFT_LEN * ACC_LEN; i++) send(16'sd1, 0);
    wait_drain("post_rst");
    cycles(10);
    check("post_rst_out_count", out_cnt, FFT_LEN);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
